mpx_controller: RTL and testbench
=================================

MPX_CONTROLLER -- requirements
Module: mpx_controller

Interface
REQ-001 Parameters SHALL be: DW, default 8, data/instruction width (>=8); WAIT_EN, default 1, honour mem_ready when 1 and treat it as constant 1 when 0.
REQ-002 Ports SHALL be:
- clk  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  leave IDLE/HALT.
- instr  in  DW  IR contents; opcode = instr[DW-1:DW-5].
- zero, pos  in  1  ALU condition flags.
- mem_ready  in  1  memory access completes this cycle.
- in_valid  in  1  input port holds data.
- out_ready  in  1  output port accepts data.
- mem_req  out  1  memory access request.
- iord  out  1  0 = PC address, 1 = operand address.
- mem_write  out  1  store strobe.
- ir_write, pc_write, pc_src  out  1  IR load, PC load, PC source (1 = branch target).
- acc_write  out  1  accumulator load.
- acc_src  out  2  00 = ALU, 01 = memory, 10 = input port.
- alu_control  out  2  00 = add, 01 = sub, 10 = and.
- out_write  out  1  output register load.
- halted  out  1  in HALT.
- instr_done  out  1  one-cycle retire pulse.

Function
REQ-003 State set SHALL be IDLE, FETCH, DECODE, MEMOP, BRANCH, IN_WAIT, OUT_WAIT, HALT.
REQ-004 IDLE: all outputs 0; start=1 -> FETCH, else stay.
REQ-005 FETCH: mem_req=1, iord=0; on mem_ready: ir_write=1 -> DECODE; otherwise stay with ir_write=0.
REQ-006 DECODE: pc_write=1, pc_src=0 (PC+1); opcode latched into op_q; next state by opcode:
- 000 LOAD, 001 STORE, 010 ADD, 011 SUB, 100 AND -> MEMOP.
- 101 JZ, 110 JPOS -> BRANCH.
- 11100 IN -> IN_WAIT; 11101 OUT -> OUT_WAIT; 1111x HALT -> HALT.
REQ-007 MEMOP: mem_req=1, iord=1; STORE also holds mem_write=1 until completion.
REQ-008 MEMOP completion: on mem_ready, LOAD asserts acc_write=1, acc_src=01; ADD/SUB/AND assert acc_write=1, acc_src=00, alu_control=00/01/10; instr_done=1; -> FETCH.
REQ-009 BRANCH (single cycle): pc_src=1; pc_write=zero for JZ, pos for JPOS, sampled this cycle; instr_done=1; -> FETCH.
REQ-010 IN_WAIT: stay while in_valid=0; when in_valid=1: acc_write=1, acc_src=10, instr_done=1 -> FETCH.
REQ-011 OUT_WAIT: out_write=out_ready; stay while out_ready=0; when out_ready=1: instr_done=1 -> FETCH.
REQ-012 HALT: halted=1, instr_done=1 on entry cycle only; start=1 -> FETCH (resume at current PC), else stay.
REQ-013 Outputs not listed for a state SHALL be 0 (no X driven); acc_src/alu_control SHALL be 00 when unused.
REQ-014 Latency with mem_ready=1, in_valid=1, out_ready=1: 3 cycles per instruction (FETCH, DECODE, execute); each wait cycle adds exactly 1.
REQ-015 Strobes acc_write, ir_write, mem_write completion and out_write SHALL fire exactly once per instruction, including during multi-cycle waits.
REQ-016 start is ignored outside IDLE and HALT; instr changes after DECODE SHALL NOT affect the executing instruction (op_q used).

Reset
REQ-017 reset=1 SHALL asynchronously force state=IDLE, op_q=0 and every output to 0; the first transition occurs on the first clk edge after deassertion.
REQ-018 Reset mid-wait (any state) SHALL abandon the access with no further strobes.

Structure
REQ-019 Package mpx_pkg SHALL hold the state enumeration, opcode constants, and acc_src/alu_control encodings.
REQ-020 Combinational opcode decode SHALL be sub-module mpx_decode (instr -> instruction class + alu_control); the FSM stays in mpx_controller.

Verification
REQ-021 Benches SHALL cover:
- LOAD 0x05 with mem_ready=1 -> IDLE->FETCH->DECODE->MEMOP; acc_write/acc_src=01 in cycle 3; instr_done once.
- STORE with mem_ready held low 4 cycles -> mem_write and mem_req high 5 cycles; single completion; -> FETCH.
- JZ with zero=1, then zero=0 -> pc_write=1, pc_src=1 in BRANCH; then pc_write=0.
- IN with in_valid low 3 cycles -> one acc_write with acc_src=10 in cycle 4 of wait; OUT with out_ready=1 -> one out_write.
- HALT (0xF0) -> halted stays 1 for 10 cycles; start pulse -> FETCH; halted=0.
- Reset asserted mid-MEMOP between clk edges -> outputs 0 immediately; IDLE; DW=16 rerun of the LOAD case passes.

Source files
------------

// File: rtl/mpx_pkg.sv
// Shared types and encodings for the multiplexed-datapath sequencing controller.
// The FSM and the opcode decoder both import this package.
package mpx_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_DECODE   = 3'd2,
    S_MEMOP    = 3'd3,
    S_BRANCH   = 3'd4,
    S_IN_WAIT  = 3'd5,
    S_OUT_WAIT = 3'd6,
    S_HALT     = 3'd7
  } state_t;

  // C_LOAD is zero so a cleared op_q reads as LOAD
  typedef enum logic [3:0] {
    C_LOAD  = 4'd0,
    C_STORE = 4'd1,
    C_ADD   = 4'd2,
    C_SUB   = 4'd3,
    C_AND   = 4'd4,
    C_JZ    = 4'd5,
    C_JPOS  = 4'd6,
    C_IN    = 4'd7,
    C_OUT   = 4'd8,
    C_HALT  = 4'd9
  } iclass_t;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_AND   = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_JPOS  = 3'b110;
  localparam logic [4:0] OP_IN    = 5'b11100;
  localparam logic [4:0] OP_OUT   = 5'b11101;

  localparam logic [1:0] ACC_ALU = 2'b00;
  localparam logic [1:0] ACC_MEM = 2'b01;
  localparam logic [1:0] ACC_IN  = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;

  function automatic logic is_alu_op(iclass_t c);
    return (c == C_ADD) || (c == C_SUB) || (c == C_AND);
  endfunction

endpackage

// File: rtl/mpx_decode.sv
// Combinational opcode decode: instruction word to instruction class and ALU op.
// Only the top five bits of the word carry the opcode.
module mpx_decode
  import mpx_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] instr,
  output iclass_t       iclass,
  output logic [1:0]    alu_control
);

  logic [4:0] opcode;
  logic       unused_operand;

  assign opcode         = instr[DW-1 -: 5];
  assign unused_operand = ^instr[DW-6:0];

  always_comb begin
    iclass      = C_HALT;
    alu_control = ALU_ADD;
    case (opcode[4:2])
      OP_LOAD:  iclass = C_LOAD;
      OP_STORE: iclass = C_STORE;
      OP_ADD: begin
        iclass      = C_ADD;
        alu_control = ALU_ADD;
      end
      OP_SUB: begin
        iclass      = C_SUB;
        alu_control = ALU_SUB;
      end
      OP_AND: begin
        iclass      = C_AND;
        alu_control = ALU_AND;
      end
      OP_JZ:    iclass = C_JZ;
      OP_JPOS:  iclass = C_JPOS;
      default: begin
        if (opcode == OP_IN)
          iclass = C_IN;
        else if (opcode == OP_OUT)
          iclass = C_OUT;
        else
          iclass = C_HALT;
      end
    endcase
  end

endmodule

// File: rtl/mpx_controller.sv
// Sequencing FSM for a multiplexed accumulator datapath: fetch, decode, execute
// with handshaked memory and I/O waits.
//
// state      | meaning
// IDLE       | after reset, waiting for start
// FETCH      | reading instruction at PC into IR
// DECODE     | PC+1, opcode latched into op_q
// MEMOP      | operand access for LOAD/STORE/ADD/SUB/AND
// BRANCH     | conditional PC load from branch target
// IN_WAIT    | waiting for input port data
// OUT_WAIT   | waiting for output port acceptance
// HALT       | stopped; start resumes at current PC
module mpx_controller
  import mpx_pkg::*;
#(
  parameter int DW      = 8,
  parameter bit WAIT_EN = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] instr,
  input  logic          zero,
  input  logic          pos,
  input  logic          mem_ready,
  input  logic          in_valid,
  input  logic          out_ready,
  output logic          mem_req,
  output logic          iord,
  output logic          mem_write,
  output logic          ir_write,
  output logic          pc_write,
  output logic          pc_src,
  output logic          acc_write,
  output logic [1:0]    acc_src,
  output logic [1:0]    alu_control,
  output logic          out_write,
  output logic          halted,
  output logic          instr_done
);

  state_t     state, state_nxt;
  iclass_t    op_q, dec_class, class_nxt;
  logic [1:0] alu_q, dec_alu;
  logic       rdy, mem_done, in_take, out_take, branch_take;
  logic       pc_dec_q, halt_entry_q;

  assign rdy = WAIT_EN ? mem_ready : 1'b1;

  mpx_decode #(.DW(DW)) u_decode (
    .instr       (instr),
    .iclass      (dec_class),
    .alu_control (dec_alu)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_HALT: if (start) state_nxt = S_FETCH;
      S_FETCH:        if (rdy) state_nxt = S_DECODE;
      S_DECODE: begin
        case (dec_class)
          C_JZ, C_JPOS: state_nxt = S_BRANCH;
          C_IN:         state_nxt = S_IN_WAIT;
          C_OUT:        state_nxt = S_OUT_WAIT;
          C_HALT:       state_nxt = S_HALT;
          default:      state_nxt = S_MEMOP;
        endcase
      end
      S_MEMOP:        if (rdy) state_nxt = S_FETCH;
      S_BRANCH:       state_nxt = S_FETCH;
      S_IN_WAIT:      if (in_valid) state_nxt = S_FETCH;
      S_OUT_WAIT:     if (out_ready) state_nxt = S_FETCH;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // op_q only moves in DECODE, so later instr changes cannot disturb execution
  assign class_nxt = (state == S_DECODE) ? dec_class : op_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      op_q         <= C_LOAD;
      alu_q        <= ALU_ADD;
      mem_req      <= 1'b0;
      iord         <= 1'b0;
      mem_write    <= 1'b0;
      pc_dec_q     <= 1'b0;
      pc_src       <= 1'b0;
      halted       <= 1'b0;
      halt_entry_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      op_q         <= class_nxt;
      if (state == S_DECODE)
        alu_q      <= dec_alu;
      mem_req      <= (state_nxt == S_FETCH) || (state_nxt == S_MEMOP);
      iord         <= (state_nxt == S_MEMOP);
      mem_write    <= (state_nxt == S_MEMOP) && (class_nxt == C_STORE);
      pc_dec_q     <= (state_nxt == S_DECODE);
      pc_src       <= (state_nxt == S_BRANCH);
      halted       <= (state_nxt == S_HALT);
      halt_entry_q <= (state_nxt == S_HALT) && (state != S_HALT);
    end
  end

  // Completion strobes qualify the registered state with this cycle's handshake
  assign mem_done    = (state == S_MEMOP) && rdy;
  assign in_take     = (state == S_IN_WAIT) && in_valid;
  assign out_take    = (state == S_OUT_WAIT) && out_ready;
  assign branch_take = (op_q == C_JZ) ? zero : pos;

  assign ir_write    = (state == S_FETCH) && rdy;
  assign pc_write    = pc_dec_q || (pc_src && branch_take);
  assign acc_write   = (mem_done && (op_q != C_STORE)) || in_take;
  assign acc_src     = in_take ? ACC_IN :
                       (mem_done && (op_q == C_LOAD)) ? ACC_MEM : ACC_ALU;
  assign alu_control = (mem_done && is_alu_op(op_q)) ? alu_q : ALU_ADD;
  assign out_write   = out_take;
  assign instr_done  = mem_done || pc_src || in_take || out_take || halt_entry_q;

endmodule

// File: tb/tb_mpx_controller.sv
// Scoreboard bench: a phase-level reference model predicts every output per cycle
// for both an 8-bit and a 16-bit controller driven with identical stimulus.
module tb_mpx_controller;

  typedef struct packed {
    logic       mem_req, iord, mem_write, ir_write, pc_write, pc_src, acc_write;
    logic [1:0] acc_src, alu_control;
    logic       out_write, halted, instr_done;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, zero = 1'b0, pos = 1'b0;
  logic mem_ready = 1'b1, in_valid = 1'b1, out_ready = 1'b1;
  logic [7:0]  instr = 8'h00;
  logic [15:0] instr16 = 16'h0000;

  logic m8_req, m8_iord, m8_mw, m8_irw, m8_pcw, m8_pcs, m8_aw, m8_ow, m8_h, m8_d;
  logic [1:0] m8_as, m8_alu;
  logic m16_req, m16_iord, m16_mw, m16_irw, m16_pcw, m16_pcs, m16_aw, m16_ow, m16_h, m16_d;
  logic [1:0] m16_as, m16_alu;
  vec_t got8, got16;

  assign got8  = {m8_req, m8_iord, m8_mw, m8_irw, m8_pcw, m8_pcs, m8_aw,
                  m8_as, m8_alu, m8_ow, m8_h, m8_d};
  assign got16 = {m16_req, m16_iord, m16_mw, m16_irw, m16_pcw, m16_pcs, m16_aw,
                  m16_as, m16_alu, m16_ow, m16_h, m16_d};

  mpx_controller #(.DW(8), .WAIT_EN(1'b1)) dut8 (
    .clk(clk), .reset(reset), .start(start), .instr(instr), .zero(zero), .pos(pos),
    .mem_ready(mem_ready), .in_valid(in_valid), .out_ready(out_ready),
    .mem_req(m8_req), .iord(m8_iord), .mem_write(m8_mw), .ir_write(m8_irw),
    .pc_write(m8_pcw), .pc_src(m8_pcs), .acc_write(m8_aw), .acc_src(m8_as),
    .alu_control(m8_alu), .out_write(m8_ow), .halted(m8_h), .instr_done(m8_d)
  );

  mpx_controller #(.DW(16), .WAIT_EN(1'b1)) dut16 (
    .clk(clk), .reset(reset), .start(start), .instr(instr16), .zero(zero), .pos(pos),
    .mem_ready(mem_ready), .in_valid(in_valid), .out_ready(out_ready),
    .mem_req(m16_req), .iord(m16_iord), .mem_write(m16_mw), .ir_write(m16_irw),
    .pc_write(m16_pcw), .pc_src(m16_pcs), .acc_write(m16_aw), .acc_src(m16_as),
    .alu_control(m16_alu), .out_write(m16_ow), .halted(m16_h), .instr_done(m16_d)
  );

  always #5 clk = ~clk;

  vec_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  bit       s_reset = 1'b1, s_start = 1'b0, s_zero = 1'b0, s_pos = 1'b0;
  bit       s_rdy = 1'b1, s_inv = 1'b1, s_outr = 1'b1;
  bit [7:0] s_instr = 8'h00;

  // Model: phase 0 idle, 1 fetch, 2 decode, 3 memory op, 4 branch, 5 input, 6 output, 7 halt
  int phase = 0;
  int mop = 0;
  bit halt_new = 1'b0;

  task automatic step();
    vec_t e;
    int   nph, top;
    @(negedge clk);
    reset     = s_reset;
    start     = s_start;
    zero      = s_zero;
    pos       = s_pos;
    mem_ready = s_rdy;
    in_valid  = s_inv;
    out_ready = s_outr;
    instr     = s_instr;
    instr16   = {s_instr, 8'($urandom)};
    e   = '0;
    nph = phase;
    top = mop / 4;
    if (s_reset) begin
      nph      = 0;
      halt_new = 1'b0;
    end else begin
      case (phase)
        0: if (s_start) nph = 1;
        1: begin
          e.mem_req = 1'b1;
          if (s_rdy) begin
            e.ir_write = 1'b1;
            nph = 2;
          end
        end
        2: begin
          e.pc_write = 1'b1;
          mop = int'(s_instr) / 8;
          top = mop / 4;
          if (top <= 4) nph = 3;
          else if (top <= 6) nph = 4;
          else if (mop == 28) nph = 5;
          else if (mop == 29) nph = 6;
          else begin
            nph = 7;
            halt_new = 1'b1;
          end
        end
        3: begin
          e.mem_req   = 1'b1;
          e.iord      = 1'b1;
          e.mem_write = (top == 1);
          if (s_rdy) begin
            e.instr_done = 1'b1;
            if (top == 0) begin
              e.acc_write = 1'b1;
              e.acc_src   = 2'd1;
            end else if (top >= 2) begin
              e.acc_write   = 1'b1;
              e.alu_control = 2'(top - 2);
            end
            nph = 1;
          end
        end
        4: begin
          e.pc_src     = 1'b1;
          e.pc_write   = (top == 5) ? s_zero : s_pos;
          e.instr_done = 1'b1;
          nph = 1;
        end
        5: if (s_inv) begin
          e.acc_write  = 1'b1;
          e.acc_src    = 2'd2;
          e.instr_done = 1'b1;
          nph = 1;
        end
        6: if (s_outr) begin
          e.out_write  = 1'b1;
          e.instr_done = 1'b1;
          nph = 1;
        end
        default: begin
          e.halted     = 1'b1;
          e.instr_done = halt_new;
          halt_new     = 1'b0;
          if (s_start) nph = 1;
        end
      endcase
    end
    phase = nph;
    exp_q.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin : monitor
    vec_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (got8 !== e) begin
          miscompares++;
          $display("FAIL dw8 vec %0d: got %b expected %b", vectors, got8, e);
        end
        if (got16 !== e) begin
          miscompares++;
          $display("FAIL dw16 vec %0d: got %b expected %b", vectors, got16, e);
        end
      end
    end
  end

  initial begin
    run(2);
    s_reset = 1'b0; s_start = 1'b1; run(1); s_start = 1'b0;
    s_instr = 8'h05; run(3);                                  // LOAD
    s_instr = 8'h20; run(2); s_rdy = 1'b0; run(4); s_rdy = 1'b1; run(1);  // STORE with wait
    s_instr = 8'hA0; s_zero = 1'b1; run(3); s_zero = 1'b0; run(3);        // JZ taken / not
    s_instr = 8'hC0; s_pos = 1'b1; run(3); s_pos = 1'b0;                  // JPOS
    s_instr = 8'h40; run(3); s_instr = 8'h60; run(3); s_instr = 8'h80; run(3);
    s_instr = 8'hE0; run(2); s_inv = 1'b0; run(3); s_inv = 1'b1; run(1);  // IN with wait
    s_instr = 8'hE8; run(3);                                              // OUT
    s_instr = 8'hF0; run(2); run(10); s_start = 1'b1; run(1); s_start = 1'b0;
    s_instr = 8'h05; run(2); s_rdy = 1'b0; run(1);                        // reset mid-MEMOP
    s_reset = 1'b1; run(1); s_reset = 1'b0; s_rdy = 1'b1; run(1);
    s_start = 1'b1; run(1); s_start = 1'b0; run(3);
    for (int i = 0; i < 800; i++) begin
      s_reset = ($urandom_range(0, 99) == 0);
      s_start = ($urandom_range(0, 3) == 0);
      s_rdy   = ($urandom_range(0, 3) != 0);
      s_inv   = ($urandom_range(0, 2) != 0);
      s_outr  = ($urandom_range(0, 2) != 0);
      s_zero  = 1'($urandom);
      s_pos   = 1'($urandom);
      s_instr = 8'($urandom);
      step();
    end
    @(negedge clk);
    #4;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
